led_frame_writer: RTL and testbench

//  Wishbone master that writes pixel rectangles into the LED matrix frame buffer (RGB565, 16-bit words).

---
 rtl/led_frame_writer_pkg.sv | 31 +++
 rtl/led_frame_writer_wb.sv | 41 ++++
 rtl/led_frame_writer.sv | 188 ++++++++++++++++++
 tb/tb_led_frame_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_writer_pkg.sv
// Shared constants, op codes and one-hot state encoding for the LED frame writer.
// The optional page flip is enabled with LED_FRAME_WRITER_FLIP_EN.
package led_frame_writer_pkg;

   localparam int unsigned ADDRESS_WIDTH     = 16;
   localparam int unsigned DATA_WIDTH        = 16;
   localparam int unsigned DATA_BYTES        = 2;
   localparam logic [15:0] MATRIX_BASE       = 16'h4000;
   localparam int unsigned MATRIX_ROW_STRIDE = 32;
   localparam int unsigned MATRIX_N_ROWS     = 14;
   localparam int unsigned MATRIX_N_COLS     = 20;

   localparam logic OP_FILL = 1'b0;
   localparam logic OP_COPY = 1'b1;

   typedef enum logic [6:0] {
      StIdle     = 7'b0000001,
      StRd       = 7'b0000010,
      StWr       = 7'b0000100,
      StNext     = 7'b0001000,
      StFlipWait = 7'b0010000,
      StFlipWr   = 7'b0100000,
      StDone     = 7'b1000000
   } state_t;

   // Word offset of pixel (x, y) from a rectangle base.
   function automatic logic [15:0] pixel_offset(input logic [4:0] y, input logic [5:0] x);
      return 16'(y) * 16'(MATRIX_ROW_STRIDE) + 16'(x);
   endfunction

endpackage

// File: rtl/led_frame_writer_wb.sv
// Single classic Wishbone read/write cycle engine: bus is driven while req is high,
// done marks the acknowledged cycle and rdata holds the last read word.
module led_frame_wb_master
   import led_frame_writer_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] adr,
   input  logic [DATA_WIDTH-1:0]    dat,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic [ADDRESS_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0]    dat_o,
   output logic                     we_o,
   output logic [DATA_BYTES-1:0]    sel_o,
   output logic                     stb_o,
   output logic                     cyc_o,
   input  logic [DATA_WIDTH-1:0]    dat_i,
   input  logic                     ack_i
);

   // Outputs follow req combinationally so an async reset of the caller drops the cycle at once.
   assign cyc_o = req;
   assign stb_o = req;
   assign we_o  = req & we;
   assign sel_o = req ? {DATA_BYTES{1'b1}} : '0;
   assign adr_o = req ? adr : '0;
   assign dat_o = (req & we) ? dat : '0;
   assign done  = req & ack_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata <= '0;
      end else if (done && !we) begin
         rdata <= dat_i;
      end
   end

endmodule

// File: rtl/led_frame_writer.sv
// Wishbone master that fills or copies pixel rectangles into the LED matrix frame buffer.
// Define LED_FRAME_WRITER_FLIP_EN to add a tear-free frame-address write after the last pixel.
module led_frame_writer
   import led_frame_writer_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_op_i,
   input  logic [15:0]              cmd_src_i,
   input  logic [13:0]              cmd_dst_i,
   input  logic [5:0]               cmd_w_i,
   input  logic [4:0]               cmd_h_i,
   input  logic [15:0]              cmd_colour_i,
   output logic                     busy_o,
   output logic                     done_o,
   input  logic                     frame_complete_i,
   output logic [ADDRESS_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0]    dat_o,
   output logic                     we_o,
   output logic [DATA_BYTES-1:0]    sel_o,
   output logic                     stb_o,
   output logic                     cyc_o,
   input  logic [DATA_WIDTH-1:0]    dat_i,
   input  logic                     ack_i
);

   state_t      state_q, state_d;
   logic        op_q;
   logic [15:0] src_q, colour_q;
   logic [13:0] dst_q;
   logic [5:0]  w_q, x_q, x_d;
   logic [4:0]  h_q, y_q, y_d;

   logic        req, we, bus_done;
   logic [15:0] adr, wdat, pixel;
   logic [15:0] pix_off, src_adr;
   logic [13:0] dst_off;
   logic        skip, empty, last_col, last_row;
   state_t      finish_st;

   assign pix_off  = pixel_offset(y_q, x_q);
   assign src_adr  = src_q + pix_off;
   assign dst_off  = dst_q + pix_off[13:0];
   // Offset 0 is the frame-address register, never a pixel.
   assign skip     = (dst_off == 14'd0);
   assign empty    = (w_q == 6'd0) || (h_q == 5'd0);
   assign last_col = ((x_q + 6'd1) == w_q);
   assign last_row = ((y_q + 5'd1) == h_q);

`ifdef LED_FRAME_WRITER_FLIP_EN
   logic fc_q;
   assign finish_st = StFlipWait;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) fc_q <= 1'b0;
      else       fc_q <= frame_complete_i;
   end
`else
   logic unused_frame_complete;
   assign unused_frame_complete = frame_complete_i;
   assign finish_st = StDone;
`endif

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      req         = 1'b0;
      we          = 1'b0;
      adr         = '0;
      wdat        = '0;
      cmd_ready_o = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (cmd_valid_i) begin
               x_d = '0;
               y_d = '0;
               if (cmd_w_i == 6'd0 || cmd_h_i == 5'd0) state_d = StNext;
               else if (cmd_op_i == OP_COPY)           state_d = StRd;
               else                                    state_d = StWr;
            end
         end
         StRd: begin
            if (skip) begin
               state_d = StNext;
            end else begin
               req = 1'b1;
               adr = src_adr;
               if (bus_done) state_d = StWr;
            end
         end
         StWr: begin
            if (skip) begin
               state_d = StNext;
            end else begin
               req  = 1'b1;
               we   = 1'b1;
               adr  = MATRIX_BASE + {2'b00, dst_off};
               wdat = (op_q == OP_COPY) ? pixel : colour_q;
               if (bus_done) state_d = StNext;
            end
         end
         StNext: begin
            if (empty) begin
               state_d = StDone;
            end else if (last_col) begin
               x_d = '0;
               y_d = y_q + 5'd1;
               if (last_row) state_d = finish_st;
               else          state_d = (op_q == OP_COPY) ? StRd : StWr;
            end else begin
               x_d     = x_q + 6'd1;
               state_d = (op_q == OP_COPY) ? StRd : StWr;
            end
         end
`ifdef LED_FRAME_WRITER_FLIP_EN
         StFlipWait: begin
            if (frame_complete_i && !fc_q) state_d = StFlipWr;
         end
         StFlipWr: begin
            req  = 1'b1;
            we   = 1'b1;
            adr  = MATRIX_BASE;
            wdat = {1'b0, dst_q, 1'b0};
            if (bus_done) state_d = StDone;
         end
`endif
         StDone: begin
            done_o  = 1'b1;
            busy_o  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         op_q     <= OP_FILL;
         src_q    <= '0;
         dst_q    <= '0;
         w_q      <= '0;
         h_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         if (state_q == StIdle && cmd_valid_i) begin
            op_q     <= cmd_op_i;
            src_q    <= cmd_src_i;
            dst_q    <= cmd_dst_i;
            w_q      <= cmd_w_i;
            h_q      <= cmd_h_i;
            colour_q <= cmd_colour_i;
         end
      end
   end

   led_frame_wb_master u_wb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req   (req),
      .we    (we),
      .adr   (adr),
      .dat   (wdat),
      .done  (bus_done),
      .rdata (pixel),
      .adr_o (adr_o),
      .dat_o (dat_o),
      .we_o  (we_o),
      .sel_o (sel_o),
      .stb_o (stb_o),
      .cyc_o (cyc_o),
      .dat_i (dat_i),
      .ack_i (ack_i)
   );

endmodule

// File: tb/tb_led_frame_writer.sv
// Self-checking bench for led_frame_writer: Wishbone slave model, transfer-list model, directed tests.
module tb_led_frame_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_op;
   logic [15:0] cmd_src, cmd_colour;
   logic [13:0] cmd_dst;
   logic [5:0]  cmd_w;
   logic [4:0]  cmd_h;
   logic        busy, done, frame_complete;
   logic [15:0] adr, dat_o, dat_i;
   logic        we, stb, cyc, ack;
   logic [1:0]  sel;

   always #5 clk = ~clk;

   led_frame_writer dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .cmd_valid_i      (cmd_valid),
      .cmd_ready_o      (cmd_ready),
      .cmd_op_i         (cmd_op),
      .cmd_src_i        (cmd_src),
      .cmd_dst_i        (cmd_dst),
      .cmd_w_i          (cmd_w),
      .cmd_h_i          (cmd_h),
      .cmd_colour_i     (cmd_colour),
      .busy_o           (busy),
      .done_o           (done),
      .frame_complete_i (frame_complete),
      .adr_o            (adr),
      .dat_o            (dat_o),
      .we_o             (we),
      .sel_o            (sel),
      .stb_o            (stb),
      .cyc_o            (cyc),
      .dat_i            (dat_i),
      .ack_i            (ack)
   );

   typedef struct packed {
      logic        we;
      logic [15:0] adr;
      logic [15:0] dat;
   } xfer_t;

   logic [15:0] src_mem [0:65535];
   logic [15:0] mat     [0:16383];
   xfer_t       exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_acks = 0;
   int unsigned ack_delay = 0;
   int unsigned ack_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Slave: reads come from src_mem, writes into the matrix window land in mat.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack     <= 1'b0;
         ack_cnt <= 0;
         dat_i   <= '0;
      end else if (stb && !ack) begin
         if (ack_cnt >= ack_delay) begin
            ack     <= 1'b1;
            ack_cnt <= 0;
            if (we) begin
               if (adr[15:14] == 2'b01) mat[adr[13:0]] <= dat_o;
            end else begin
               dat_i <= src_mem[adr];
            end
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end else begin
         ack <= 1'b0;
      end
   end

   // Bus monitor: transfer order/content, hold-while-stalled, and idle gap after writes.
   logic        p_stb, p_ack, p_we;
   logic [15:0] p_adr, p_dat;
   always @(negedge clk) begin
      xfer_t e;
      if (rst) begin
         p_stb <= 1'b0;
         p_ack <= 1'b0;
      end else begin
         if (stb) check("cyc_eq_stb", {31'd0, cyc}, 32'd1);
         if (p_stb && !p_ack && stb) begin
            check("hold_adr", {16'd0, adr}, {16'd0, p_adr});
            check("hold_dat", {16'd0, dat_o}, {16'd0, p_dat});
            check("hold_we", {31'd0, we}, {31'd0, p_we});
         end
         if (p_stb && p_ack && p_we) check("gap_after_wr", {31'd0, cyc}, 32'd0);
         if (stb && ack) begin
            n_acks++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_xfer: got adr 0x%0h we %0b, want none", adr, we);
            end else begin
               e = exp_q.pop_front();
               check("xfer_we", {31'd0, we}, {31'd0, e.we});
               check("xfer_adr", {16'd0, adr}, {16'd0, e.adr});
               if (e.we) begin
                  check("xfer_dat", {16'd0, dat_o}, {16'd0, e.dat});
                  check("xfer_sel", {30'd0, sel}, 32'd3);
               end
            end
         end
         p_stb <= stb;
         p_ack <= ack;
         p_we  <= we;
         p_adr <= adr;
         p_dat <= dat_o;
      end
   end

   // Expected transfer list straight from the rectangle rules.
   task automatic build_expected(input logic op, input logic [15:0] src, input logic [13:0] dst,
                                 input int w, input int h, input logic [15:0] col, output int n);
      xfer_t e;
      int    off;
      logic [15:0] sa;
      n = 0;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            off = (int'(dst) + y * 32 + x) & 'h3FFF;
            sa  = 16'((int'(src) + y * 32 + x) & 'hFFFF);
            if (off != 0) begin
               if (op) begin
                  e = '{we: 1'b0, adr: sa, dat: 16'd0};
                  exp_q.push_back(e);
                  n++;
               end
               e = '{we: 1'b1, adr: 16'h4000 | 16'(off), dat: op ? src_mem[sa] : col};
               exp_q.push_back(e);
               n++;
            end
         end
      end
`ifdef LED_FRAME_WRITER_FLIP_EN
      if (w != 0 && h != 0) begin
         e = '{we: 1'b1, adr: 16'h4000, dat: {1'b0, dst, 1'b0}};
         exp_q.push_back(e);
         n++;
      end
`endif
   endtask

   task automatic start_cmd(input logic op, input logic [15:0] src, input logic [13:0] dst,
                            input logic [5:0] w, input logic [4:0] h, input logic [15:0] col);
      @(posedge clk); #1;
      check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
      cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_w = w; cmd_h = h; cmd_colour = col;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_src = 16'hDEAD; cmd_dst = 14'h1555; cmd_colour = 16'hBEEF;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 5000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done_o, want done_o within 5000 cycles");
      end else begin
         check("busy_at_done", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
         check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
         check("done_one_cycle", {31'd0, done}, 32'd0);
      end
      check("queue_drained", exp_q.size(), 32'd0);
   endtask

   task automatic run_cmd(input logic op, input logic [15:0] src, input logic [13:0] dst,
                          input logic [5:0] w, input logic [4:0] h, input logic [15:0] col,
                          input string name, output int lat);
      int n, a0;
      build_expected(op, src, dst, int'(w), int'(h), col, n);
      a0 = n_acks;
      start_cmd(op, src, dst, w, h, col);
      wait_done(lat);
      check({name, "_xfers"}, n_acks - a0, n);
   endtask

   initial begin
      int lat, n, k;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
      cmd_w = '0; cmd_h = '0; cmd_colour = '0; frame_complete = 1'b0;
      for (int i = 0; i < 65536; i++) src_mem[i] = 16'(i) ^ 16'h5A5A;
      src_mem[16'h8000] = 16'h1111;
      src_mem[16'h8001] = 16'h2222;
      src_mem[16'h8002] = 16'h3333;
      @(posedge clk); @(posedge clk); #1;
      check("rst_cyc", {31'd0, cyc}, 32'd0);
      check("rst_stb", {31'd0, stb}, 32'd0);
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_adr", {16'd0, adr}, 32'd0);
      check("rst_dat", {16'd0, dat_o}, 32'd0);
      check("rst_sel", {30'd0, sel}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      rst = 1'b0;

      run_cmd(1'b0, 16'h0, 14'h100, 6'd2, 5'd2, 16'hF800, "fill2x2", lat);
      check("fill_4100", {16'd0, mat[14'h100]}, 32'hF800);
      check("fill_4101", {16'd0, mat[14'h101]}, 32'hF800);
      check("fill_4120", {16'd0, mat[14'h120]}, 32'hF800);
      check("fill_4121", {16'd0, mat[14'h121]}, 32'hF800);

      run_cmd(1'b1, 16'h8000, 14'h040, 6'd3, 5'd1, 16'h0, "copy3x1", lat);
      check("copy_40", {16'd0, mat[14'h040]}, 32'h1111);
      check("copy_41", {16'd0, mat[14'h041]}, 32'h2222);
      check("copy_42", {16'd0, mat[14'h042]}, 32'h3333);

      ack_delay = 5;
      run_cmd(1'b1, 16'h8000, 14'h080, 6'd3, 5'd2, 16'h0, "copy_slow", lat);
      run_cmd(1'b0, 16'h0, 14'h2A0, 6'd32, 5'd1, 16'h1234, "fill_slow_w32", lat);
      check("fill_w32_last", {16'd0, mat[14'h2BF]}, 32'h1234);
      ack_delay = 0;

      run_cmd(1'b0, 16'h0, 14'h0, 6'd0, 5'd5, 16'hFFFF, "empty_w0", lat);
      check("empty_w0_latency", lat, 32'd1);
      run_cmd(1'b1, 16'h8000, 14'h10, 6'd3, 5'd0, 16'h0, "empty_h0", lat);
      check("empty_h0_latency", lat, 32'd1);

      // Destination wrap: offset 0 must be skipped.
      run_cmd(1'b0, 16'h0, 14'h3FFE, 6'd3, 5'd1, 16'h07E0, "fill_wrap", lat);
      check("wrap_3ffe", {16'd0, mat[14'h3FFE]}, 32'h07E0);
      check("wrap_3fff", {16'd0, mat[14'h3FFF]}, 32'h07E0);
      run_cmd(1'b1, 16'hFFFF, 14'h3FF0, 6'd2, 5'd1, 16'h0, "copy_src_wrap", lat);
      check("srcwrap_3ff0", {16'd0, mat[14'h3FF0]}, 32'hA5A5);
      check("srcwrap_3ff1", {16'd0, mat[14'h3FF1]}, 32'h5A5A);
      run_cmd(1'b1, 16'h8000, 14'h3FFF, 6'd2, 5'd1, 16'h0, "copy_skip", lat);
      check("copyskip_3fff", {16'd0, mat[14'h3FFF]}, 32'h1111);

      // Reset in the middle of a stalled write.
      ack_delay = 5;
      start_cmd(1'b0, 16'h0, 14'h300, 6'd4, 5'd1, 16'hAAAA);
      k = 0;
      while (!(stb && we) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("midwr_reached", {31'd0, stb & we}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("midwr_cyc", {31'd0, cyc}, 32'd0);
      check("midwr_stb", {31'd0, stb}, 32'd0);
      check("midwr_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      ack_delay = 0;
      run_cmd(1'b0, 16'h0, 14'h310, 6'd1, 5'd1, 16'h5555, "after_reset", lat);
      check("after_reset_310", {16'd0, mat[14'h310]}, 32'h5555);

`ifdef LED_FRAME_WRITER_FLIP_EN
      build_expected(1'b0, 16'h0, 14'h200, 1, 1, 16'h001F, n);
      k = n_acks;
      start_cmd(1'b0, 16'h0, 14'h200, 6'd1, 5'd1, 16'h001F);
      repeat (30) @(posedge clk);
      #1;
      check("flip_waits", n_acks - k, 32'd1);
      check("flip_not_done", {31'd0, busy}, 32'd1);
      frame_complete = 1'b1;
      @(posedge clk); #1;
      frame_complete = 1'b0;
      wait_done(lat);
      check("flip_xfers", n_acks - k, n);
      check("flip_frame_reg", {16'd0, mat[14'h0]}, 32'h0400);
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
